// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled 8N1 UART receiver feeding a first-word-fall-through
// byte FIFO. Start-bit glitches are rejected, a low stop bit raises frame_err
// once per break, and a completed byte that finds the FIFO full raises overrun.
module uart_rx_fifo #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                       clk100,
    input  logic                       reset,
    input  logic                       rxd,
    output logic [7:0]                 m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT + 1);
    localparam int AW           = $clog2(DEPTH);
    localparam int CW           = $clog2(DEPTH + 1);

    // Timer counts down to zero; the reload is one less than the wait length
    // so the sample lands exactly HALF_BIT / CLKS_PER_BIT cycles after loading.
    localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_BIT - 1);
    localparam logic [CW-1:0] DEPTH_CNT   = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    // Pointer advance; the extra MSB distinguishes full from empty.
    function automatic logic [AW:0] ptr_next(input logic [AW:0] ptr);
        ptr_next = ptr + {{AW{1'b0}}, 1'b1};
    endfunction

    logic          rx_meta_r;
    logic          rxs_r;
    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          frame_err_r;
    logic          overrun_r;
    logic [7:0]    mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          tick_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          wr_ok_s;

    assign tick_s  = (timer_r == {TW{1'b0}});
    // A push request is raised on the stop-bit sample cycle with a high line.
    assign push_s  = (state_r == STOP) && tick_s && rxs_r;
    assign m_valid = (count_r != {CW{1'b0}});
    assign pop_s   = m_valid && m_ready;
    assign full_s  = (count_r == DEPTH_CNT);
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign wr_ok_s = push_s && (!full_s || pop_s);

    assign m_data    = mem_r[rd_ptr_r[AW-1:0]];
    assign count     = count_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

    // Two-flop synchroniser on the raw serial line; idles high.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rxs_r     <= rx_meta_r;
        end
    end

    // Receive state machine: start validation, data sampling, stop check, break wait.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            timer_r     <= {TW{1'b0}};
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'd0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!rxs_r) begin
                        timer_r <= HALF_RELOAD;
                        state_r <= START;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (!rxs_r) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                            timer_r   <= FULL_RELOAD;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state_r <= IDLE;
                        end
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shift_r[bit_idx_r] <= rxs_r;
                        timer_r            <= FULL_RELOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (rxs_r) begin
                            state_r <= IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= BREAK;
                        end
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                BREAK: begin
                    // Held-low line: wait for idle so only one error is reported.
                    if (rxs_r) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the overrun pulse.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= {(AW+1){1'b0}};
            rd_ptr_r  <= {(AW+1){1'b0}};
            count_r   <= {CW{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= push_s && full_s && !pop_s;
            if (wr_ok_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({wr_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk100) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames,
// compared every cycle against a queue-based model of the receiver and FIFO.
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 2_000_000;
    localparam int BAUD   = 100_000;
    localparam int DEPTH  = 16;
    localparam int C      = CLK_HZ / BAUD;   // 20 clocks per bit
    localparam int H      = C / 2;
    localparam int LAT    = 3;               // pin edge to START entry, synchroniser included
    localparam int STOP_OFS = LAT + H + 9 * C;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        bit         good;
    } pend_t;

    logic       clk100 = 1'b0;
    logic       reset  = 1'b1;
    logic       rxd    = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk100    (clk100),
        .reset     (reset),
        .rxd       (rxd),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk100 = ~clk100;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         fe_seen = 0;
    int         ov_seen = 0;
    int         ready_mode = 0;   // 0 low, 1 high, 2 random, 3 only at edge force_cyc
    int         force_cyc = -1;
    bit         ready_at_edge = 1'b0;
    logic [7:0] model_q[$];
    logic [7:0] popped_log[$];
    pend_t      pend[$];

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model update and per-cycle comparison, then m_ready for the next edge.
    always @(negedge clk100) begin : cmp
        pend_t ev;
        bit    pop;
        bit    push;
        bit    bad_ev;
        bit    ov_exp;
        pop = 1'b0; push = 1'b0; bad_ev = 1'b0; ov_exp = 1'b0;
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
        if (reset) begin
            model_q.delete();
            pend.delete();
            chk("rst_valid", 32'(m_valid), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_frame_err", 32'(frame_err), 32'd0);
            chk("rst_overrun", 32'(overrun), 32'd0);
        end else begin
            pop = (model_q.size() > 0) && ready_at_edge;
            if (pend.size() > 0 && pend[0].cyc == cyc) begin
                ev = pend.pop_front();
                if (ev.good) begin
                    if (model_q.size() < DEPTH || pop) push = 1'b1;
                    else ov_exp = 1'b1;
                end else begin
                    bad_ev = 1'b1;
                end
            end
            if (pop) begin
                popped_log.push_back(model_q[0]);
                void'(model_q.pop_front());
            end
            if (push) model_q.push_back(ev.b);
            chk("valid", 32'(m_valid), 32'(model_q.size() > 0));
            chk("count", 32'(count), 32'(model_q.size()));
            if (model_q.size() > 0) chk("data", 32'(m_data), 32'(model_q[0]));
            chk("frame_err", 32'(frame_err), 32'(bad_ev));
            chk("overrun", 32'(overrun), 32'(ov_exp));
        end
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = 1'($urandom_range(0, 1));
            3:       m_ready = (cyc + 1 == force_cyc);
            default: m_ready = 1'b0;
        endcase
        ready_at_edge = m_ready;
    end

    // All waits keep the bench aligned to 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good_stop, input int extra_low);
        pend_t ev;
        ev.cyc = cyc + STOP_OFS;
        ev.b = b;
        ev.good = good_stop;
        pend.push_back(ev);
        rxd = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(C);
        end
        rxd = good_stop;
        idle(C);
        if (!good_stop) idle(extra_low * C);
        rxd = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        ready_mode = 1;
        while (m_valid === 1'b1 && t < 4 * DEPTH) begin
            idle(1);
            t++;
        end
        idle(2);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int fe0;
        int ov0;
        logic [7:0] b;
        bit good;
        @(posedge clk100); #1;
        idle(3);
        reset = 1'b0;
        idle(5);

        // Single byte, then a one-cycle pop.
        ready_mode = 0;
        send_frame(8'h55, 1'b1, 0);
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'h55);
        chk("single_count", 32'(count), 32'd1);
        force_cyc = cyc + 1;
        ready_mode = 3;
        idle(2);
        chk("single_pop_valid", 32'(m_valid), 32'd0);
        chk("single_pop_count", 32'(count), 32'd0);
        ready_mode = 0;

        // Start-bit glitch shorter than half a bit.
        fe0 = fe_seen;
        rxd = 1'b0;
        idle(6);
        rxd = 1'b1;
        idle(2 * C);
        chk("glitch_count", 32'(count), 32'd0);
        chk("glitch_fe", 32'(fe_seen - fe0), 32'd0);

        // Framing error with a long break, then a good byte.
        fe0 = fe_seen;
        send_frame(8'hA3, 1'b0, 3);
        idle(4);
        chk("frame_fe_pulses", 32'(fe_seen - fe0), 32'd1);
        chk("frame_count", 32'(count), 32'd0);
        send_frame(8'h3C, 1'b1, 0);
        chk("frame_next_data", 32'(m_data), 32'h3C);
        chk("frame_next_count", 32'(count), 32'd1);
        drain();
        ready_mode = 0;

        // Overrun on the 17th byte, drain order.
        ov0 = ov_seen;
        popped_log.delete();
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 0);
        chk("ovr_count", 32'(count), 32'd16);
        chk("ovr_pulses", 32'(ov_seen - ov0), 32'd1);
        drain();
        chk("ovr_drained", 32'(popped_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < popped_log.size(); i++)
            chk("ovr_order", 32'(popped_log[i]), 32'(i));

        // Full FIFO with a pop on the stop-sample edge accepts the byte.
        ready_mode = 0;
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 0);
        ov0 = ov_seen;
        force_cyc = cyc + STOP_OFS;
        ready_mode = 3;
        send_frame(8'hFA, 1'b1, 0);
        chk("full_pop_count", 32'(count), 32'd16);
        chk("full_pop_ovr", 32'(ov_seen - ov0), 32'd0);
        popped_log.delete();
        drain();
        if (popped_log.size() > 0) chk("full_pop_last", 32'(popped_log[popped_log.size() - 1]), 32'hFA);
        else chk("full_pop_last", 32'd0, 32'hFA);

        // Back-to-back frames while the consumer is always ready.
        ready_mode = 1;
        popped_log.delete();
        fe0 = fe_seen;
        ov0 = ov_seen;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'hFA, 1'b1, 0);
        idle(4);
        chk("b2b_n", 32'(popped_log.size()), 32'd3);
        if (popped_log.size() == 3) begin
            chk("b2b_0", 32'(popped_log[0]), 32'h00);
            chk("b2b_1", 32'(popped_log[1]), 32'hFF);
            chk("b2b_2", 32'(popped_log[2]), 32'hFA);
        end
        chk("b2b_flags", 32'((fe_seen - fe0) + (ov_seen - ov0)), 32'd0);

        // Reset during data bit 4 of 0x81, then a good byte.
        ready_mode = 0;
        b = 8'h81;
        rxd = 1'b0;
        idle(C);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            idle(C);
        end
        rxd = b[4];
        idle(H);
        reset = 1'b1;
        rxd = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2 * C);
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_valid", 32'(m_valid), 32'd0);
        send_frame(8'h19, 1'b1, 0);
        chk("rst_next_data", 32'(m_data), 32'h19);
        chk("rst_next_count", 32'(count), 32'd1);
        drain();

        // Random frames, random stop errors, random consumer stalls.
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 9) != 0);
            send_frame(b, good, int'($urandom_range(0, 2)));
            if (!good) idle(int'($urandom_range(2, 40)));
            else if ($urandom_range(0, 3) != 0) idle(int'($urandom_range(1, 40)));
        end
        idle(C);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampled UART receiver with a byte FIFO, placed between the `rxd` pin and the pattern-generator command parser. It synchronises the serial line and rejects start-bit glitches. It flags framing errors and buffers received bytes behind a valid/ready interface. The parser can then stall, for example during a BRAM write, without losing host bytes.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate. `CLKS_PER_BIT = CLK_HZ / BAUD`, integer truncation (868 at defaults).
- `DEPTH`, 16, FIFO depth in bytes; must be a power of two, ≥2.
- `clk100  in  1  system clock; all logic on its rising edge.`
- `reset  in  1  asynchronous, active-high reset.`
- `rxd  in  1  raw serial line, idle high, 8N1, LSB first.`
- `m_data  out  8  byte at FIFO head; valid only while m_valid=1.`
- `m_valid  out  1  FIFO not empty.`
- `m_ready  in  1  consumer accepts m_data this cycle.`
- `count  out  $clog2(DEPTH+1)  bytes currently held.`
- `frame_err  out  1  one-cycle pulse: stop bit sampled low.`
- `overrun  out  1  one-cycle pulse: completed byte dropped because FIFO full.`

## Operation
- **Synchroniser:** 2-flop chain on `rxd`, reset value 1. All decisions use the second-flop output `rxs`.
- **States:** IDLE, START, DATA, STOP, BREAK. There is one bit-timer counter (width fits `CLKS_PER_BIT`) and one 3-bit bit index.
- **IDLE:** on the first cycle with `rxs`=0, load the timer and go to START.
- **START:** wait `CLKS_PER_BIT/2` cycles (integer division), then sample `rxs`.
  - `rxs`=0: go to DATA, bit index 0, timer reloaded.
  - `rxs`=1: glitch. Return to IDLE, no flags.
- **DATA:** every `CLKS_PER_BIT` cycles, sample `rxs` into shift register bit [index]. After bit 7, go to STOP.
- **STOP:** after `CLKS_PER_BIT` cycles, sample `rxs`.
  - `rxs`=1: push the byte, go to IDLE.
  - `rxs`=0: pulse `frame_err`, discard the byte, go to BREAK.
- **BREAK:** stay until `rxs`=1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- **FIFO:** circular buffer, first-word-fall-through, pointers one bit wider than the address.
  - A pop occurs when `m_valid & m_ready`.
  - A push is accepted if `count < DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overrun` pulses. FIFO contents are unchanged.
  - Simultaneous push and pop: `count` unchanged, order preserved.
  - Pointers wrap modulo `DEPTH`.
- `m_ready` while `m_valid`=0 has no effect.
- **Reset values (any time, including mid-byte):**
  - State returns to IDLE.
  - FIFO is emptied (`count`=0, `m_valid`=0).
  - `frame_err`=0, `overrun`=0, synchroniser flops set to 1.
  - `m_data` is don't-care while `m_valid`=0.
  - A partial byte is discarded. After reset, reception resumes on the next falling edge.

## Timing
- `rxd` falling edge → IDLE→START: 2–3 cycles (synchroniser).
- Data bit n is sampled `CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT` cycles after START entry; stop bit at n=8.
- Stop-bit sample cycle → push is registered. The same byte appears on `m_data` with `m_valid`=1 on the following cycle.
- `frame_err` and `overrun` are asserted for exactly the cycle after the stop-bit sample.
- After a good stop bit the machine is in IDLE one cycle later. Back-to-back frames with a one-bit stop are received without loss.
- Pop: `m_data`/`m_valid` reflect the next entry in the cycle after the handshake. `count` is updated on the same edge.
- Tolerated baud mismatch is ±4% cumulative over 10 bits.

## Test plan
- **Single byte:** send 0x55 at 115200 with `m_ready`=0.
  - One cycle after the stop sample: `m_valid`=1, `m_data`=0x55, `count`=1.
  - Assert `m_ready` for one cycle: `m_valid`=0, `count`=0.
- **Glitch reject:** drive `rxd` low for 200 cycles (less than half a bit), then high.
  - No push, no `frame_err`; state back in IDLE.
- **Framing error:** send 0xA3 with the stop bit low, then hold low for 3 bit times.
  - Exactly one `frame_err` pulse, `count` stays 0.
  - Next valid byte 0x3C is received correctly.
- **Overrun:** send 17 bytes 0x00..0x10 with `m_ready`=0.
  - `count`=16, one `overrun` pulse at the 17th stop bit.
  - Draining yields 0x00..0x0F in order.
  - Then send 0xFA while holding `m_ready`=1 at `count`=16 during its stop sample: push accepted, no `overrun`.
- **Back-to-back:** send 0x00, 0xFF, 0xFA with no idle gap while `m_ready`=1.
  - Three bytes emerge in order, no flags.
- **Reset mid-byte:** assert `reset` for 3 cycles during DATA bit 4 of 0x81.
  - Outputs return to reset values, no byte pushed.
  - A following 0x19 is received correctly.
